vga_wbuf_ctrl: RTL and testbench
================================

// Module: vga_wbuf_ctrl
// PURPOSE
// Posted-write buffer and RAM access sequencer for the VGA text/color RAMs. CPU writes to 0xE000-0xFFFF
// are queued in a small FIFO and drained into text RAM (a[12]=0) or color RAM (a[12]=1) only while the
// scan-out does not own the RAMs, so the CPU stalls only when the FIFO is full, not for whole active lines.
// Sits between the CPU bus decode and the RAM chip-select/strobe pins, next to the VGA timing decode.
// PARAMETERS
// DEPTH   4   FIFO entries; power of two, 2..16
// PORTS
// clk          in   1   system clock; all logic rising-edge
// rst          in   1   asynchronous reset, active-high
// wr_req       in   1   CPU write request, sampled each clk; held by CPU until accepted
// wr_addr      in   16  CPU write address
// wr_data      in   8   CPU write data
// n_rdy        out  1   0 = request accepted this cycle / no stall; 1 = stall (FIFO full)
// ram_busy     in   1   scan-out owns RAMs (active pixel fetch region)
// busy_soon    in   1   ram_busy will assert within 3 clk; no new drain may start
// a_sel        out  1   RAM address mux: 0 = scan-out counters, 1 = ram_a
// ram_a        out  12  RAM address during drain (wr_addr[11:0] of head entry)
// ram_d        out  8   RAM data during drain
// n_d_oe       out  1   0 = drive ram_d onto RAM data bus
// n_text_cs    out  1   text RAM chip select during drain, active-low
// n_text_we    out  1   text RAM write strobe, active-low
// n_color_cs   out  1   color RAM chip select during drain, active-low
// n_color_we   out  1   color RAM write strobe, active-low
// abort_err    out  1   sticky: ram_busy rose during a drain sequence; cleared only by rst
// BEHAVIOUR
// - Reset: FIFO empty, state IDLE, n_rdy=0, a_sel=0, n_d_oe=1, all n_*_cs/n_*_we=1, ram_a=0, ram_d=0,
//   abort_err=0. Reset mid-sequence drops the queue and deasserts all strobes asynchronously.
// - Entry = {wr_addr[12:0], wr_data}. Accept: wr_req=1 & wr_addr[15:13]==3'b111 & count<DEPTH -> push.
//   wr_req to other addresses: ignored, n_rdy=0 (not this block's space). full (count==DEPTH) -> n_rdy=1.
// - n_rdy is combinational: wr_req & in-range & full. count is registered; a pop in the same cycle
//   does NOT free space for the current request (accepted next cycle).
// - Drain FSM (one entry per 4 clk):
//   IDLE  : if !empty & !ram_busy & !busy_soon -> SETUP.
//   SETUP : a_sel=1, n_d_oe=0, selected cs=0, we=1; ram_a/ram_d from head -> STROBE.
//   STROBE: as SETUP plus selected we=0 -> HOLD.
//   HOLD  : we=1, cs=0, n_d_oe=0 -> IDLE, pop head.
//   Selected RAM: entry addr[12]=0 text, 1 color; the other RAM's cs/we stay 1.
// - Abort: ram_busy=1 in SETUP/STROBE/HOLD -> next clk IDLE, all strobes 1, a_sel=0, head NOT popped
//   (retried later), abort_err<=1. ram_busy has priority over FSM advance.
// - Outputs a_sel, n_d_oe, cs, we registered (glitch-free); ram_a/ram_d stable from SETUP through HOLD.
// - Push and pop in the same cycle: both happen, count unchanged. Pointers wrap modulo DEPTH.
// - Write ordering preserved: FIFO strictly in order; no read bypass (reads are outside this block).
// CONFIGURATION
// VGA_WBUF_COALESCE_EN defined: an accepted write whose addr[12:0] equals the newest queued entry,
//   when that entry is not the head in SETUP/STROBE/HOLD, overwrites its data instead of pushing
//   (count unchanged); accepted even if full.
// Not defined: every accepted write pushes a new entry; full always stalls.
// TESTING
// 1 rst, ram_busy=0: wr 0xE005<=0x41 -> SETUP +1clk, n_text_we=0 for 1clk, ram_a=0x005, ram_d=0x41, empty.
// 2 ram_busy=1, 5 wr to 0xF000..0xF004 (DEPTH=4) -> 4 accepted, 5th n_rdy=1 until ram_busy=0 & first pop;
//   then 5 color writes in address order, 4 clk apart.
// 3 wr 0x8000<=0xAA -> n_rdy=0, no push, no RAM strobe.
// 4 drain started, ram_busy=1 in STROBE -> IDLE, strobes 1, abort_err=1; entry rewritten after ram_busy=0.
// 5 busy_soon=1, entry queued -> FSM stays IDLE, a_sel=0 until busy_soon=0 & ram_busy=0.
// 6 COALESCE_EN, ram_busy=1: wr 0xE010<=1, 0xE010<=2 -> count=1; drain writes 0x02 once. Without: 2 writes.

Source files
------------

// File: rtl/vga_wbuf_ctrl.sv
// -----------------------------------------------------------------------------
// vga_wbuf_ctrl
// Posted-write buffer and RAM access sequencer for the VGA text/color RAMs.
// CPU writes to 0xE000-0xFFFF are queued in a small FIFO and drained into the
// text RAM (addr[12]=0) or color RAM (addr[12]=1) only while the scan-out does
// not own the RAMs. The CPU stalls only when the FIFO is full.
//
// Optional feature macro: VGA_WBUF_COALESCE_EN
//   defined   : a write whose addr[12:0] matches the newest queued entry
//               overwrites that entry's data (unless that entry is the head
//               currently being drained); accepted even when full.
//   undefined : every accepted write pushes a new entry; full always stalls.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   wr_req/addr/data    CPU write request, held by the CPU until accepted
//   n_rdy               1 = stall (in-range request while FIFO full)
//   ram_busy            scan-out owns the RAMs; aborts any drain in progress
//   busy_soon           ram_busy will rise within 3 clk; blocks a new drain
//   a_sel               RAM address mux select (1 = ram_a)
//   ram_a, ram_d        address/data of the entry being drained
//   n_d_oe              0 = drive ram_d onto the RAM data bus
//   n_text_cs/we        text RAM chip select / write strobe, active-low
//   n_color_cs/we       color RAM chip select / write strobe, active-low
//   abort_err           sticky flag: ram_busy rose during a drain sequence
//
// Handshake: the CPU holds wr_req/wr_addr/wr_data stable; the request is
// taken on the rising edge of any cycle in which it is in range and n_rdy=0.
// -----------------------------------------------------------------------------
module vga_wbuf_ctrl #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_req,
   input  logic [15:0] wr_addr,
   input  logic [7:0]  wr_data,
   output logic        n_rdy,
   input  logic        ram_busy,
   input  logic        busy_soon,
   output logic        a_sel,
   output logic [11:0] ram_a,
   output logic [7:0]  ram_d,
   output logic        n_d_oe,
   output logic        n_text_cs,
   output logic        n_text_we,
   output logic        n_color_cs,
   output logic        n_color_we,
   output logic        abort_err
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

   state_t        state_q;
   logic [20:0]   mem_q [DEPTH];   // {addr[12:0], data}
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic          a_sel_q, n_d_oe_q, abort_err_q, color_q;
   logic          n_text_cs_q, n_text_we_q, n_color_cs_q, n_color_we_q;
   logic [11:0]   ram_a_q;
   logic [7:0]    ram_d_q;

   logic          in_range, full, empty, push, pop, coal_hit;
   logic [20:0]   head;

   assign in_range = (wr_addr[15:13] == 3'b111);
   assign full     = (count_q == CW'(DEPTH));
   assign empty    = (count_q == '0);
   assign head     = mem_q[rd_ptr_q];

`ifdef VGA_WBUF_COALESCE_EN
   logic [PW-1:0] newest_idx;
   logic          head_locked;
   assign newest_idx  = wr_ptr_q - PW'(1);
   // With one entry queued and a drain in flight, the newest entry is the one
   // on the RAM pins; it must not change under the strobe.
   assign head_locked = (state_q != IDLE) && (count_q == CW'(1));
   assign coal_hit    = wr_req && in_range && !empty && !head_locked &&
                        (mem_q[newest_idx][20:8] == wr_addr[12:0]);
`else
   assign coal_hit = 1'b0;
`endif

   // count is registered: a pop in this cycle does not free space for the
   // request presented in this same cycle.
   assign push  = wr_req && in_range && !full && !coal_hit;
   assign n_rdy = wr_req && in_range && full && !coal_hit;
   assign pop   = (state_q == HOLD) && !ram_busy;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: an entry is only read once count covers it.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {wr_addr[12:0], wr_data};
      end
`ifdef VGA_WBUF_COALESCE_EN
      else if (coal_hit) begin
         mem_q[newest_idx][7:0] <= wr_data;
      end
`endif
   end

   // Drain sequencer. All RAM-side outputs are registered here so they change
   // only on clock edges; ram_busy anywhere in a sequence wins over advancing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         a_sel_q      <= 1'b0;
         n_d_oe_q     <= 1'b1;
         n_text_cs_q  <= 1'b1;
         n_text_we_q  <= 1'b1;
         n_color_cs_q <= 1'b1;
         n_color_we_q <= 1'b1;
         ram_a_q      <= '0;
         ram_d_q      <= '0;
         color_q      <= 1'b0;
         abort_err_q  <= 1'b0;
      end else if ((state_q != IDLE) && ram_busy) begin
         // Abort: release the bus, keep the head entry for a later retry.
         state_q      <= IDLE;
         a_sel_q      <= 1'b0;
         n_d_oe_q     <= 1'b1;
         n_text_cs_q  <= 1'b1;
         n_text_we_q  <= 1'b1;
         n_color_cs_q <= 1'b1;
         n_color_we_q <= 1'b1;
         abort_err_q  <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (!empty && !ram_busy && !busy_soon) begin
                  state_q      <= SETUP;
                  a_sel_q      <= 1'b1;
                  n_d_oe_q     <= 1'b0;
                  color_q      <= head[20];
                  ram_a_q      <= head[19:8];
                  ram_d_q      <= head[7:0];
                  n_text_cs_q  <= head[20];
                  n_color_cs_q <= !head[20];
               end
            end
            SETUP: begin
               state_q      <= STROBE;
               n_text_we_q  <= color_q;
               n_color_we_q <= !color_q;
            end
            STROBE: begin
               state_q      <= HOLD;
               n_text_we_q  <= 1'b1;
               n_color_we_q <= 1'b1;
            end
            HOLD: begin
               state_q      <= IDLE;
               a_sel_q      <= 1'b0;
               n_d_oe_q     <= 1'b1;
               n_text_cs_q  <= 1'b1;
               n_color_cs_q <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign a_sel      = a_sel_q;
   assign ram_a      = ram_a_q;
   assign ram_d      = ram_d_q;
   assign n_d_oe     = n_d_oe_q;
   assign n_text_cs  = n_text_cs_q;
   assign n_text_we  = n_text_we_q;
   assign n_color_cs = n_color_cs_q;
   assign n_color_we = n_color_we_q;
   assign abort_err  = abort_err_q;

endmodule

// File: tb/tb_vga_wbuf_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vga_wbuf_ctrl
// Self-checking bench for vga_wbuf_ctrl (DEPTH=4). Table of single-write
// vectors, hand-written multi-cycle sequences (full stall, abort, busy_soon,
// async reset, same-address writes) and a randomized run checked against a
// queue-based model of the write buffer.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_wbuf_ctrl;

   localparam int DEPTH = 4;

   // ---------------- clock / reset / DUT ----------------
   logic        clk       = 1'b0;
   logic        rst       = 1'b1;
   logic        wr_req    = 1'b0;
   logic [15:0] wr_addr   = '0;
   logic [7:0]  wr_data   = '0;
   logic        ram_busy  = 1'b0;
   logic        busy_soon = 1'b0;
   logic        n_rdy, a_sel, n_d_oe, abort_err;
   logic        n_text_cs, n_text_we, n_color_cs, n_color_we;
   logic [11:0] ram_a;
   logic [7:0]  ram_d;

   always #5 clk = ~clk;

   vga_wbuf_ctrl #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_req     (wr_req),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .n_rdy      (n_rdy),
      .ram_busy   (ram_busy),
      .busy_soon  (busy_soon),
      .a_sel      (a_sel),
      .ram_a      (ram_a),
      .ram_d      (ram_d),
      .n_d_oe     (n_d_oe),
      .n_text_cs  (n_text_cs),
      .n_text_we  (n_text_we),
      .n_color_cs (n_color_cs),
      .n_color_we (n_color_we),
      .abort_err  (abort_err)
   );

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- scoreboard ----------------
   int          checks = 0;
   int          errors = 0;
   logic [20:0] exp_q[$];   // model FIFO: {addr[12:0], data}
   logic [20:0] obs_q[$];   // observed RAM writes: {color, ram_a, ram_d}
   int          obs_t[$];
   int          asel_t;
   int          mcount, pop_dly, scan_left, scan_ph;
   logic        pending;
   logic [12:0] last_low;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // {a_sel, n_d_oe, n_text_cs, n_text_we, n_color_cs, n_color_we}
   function automatic logic [5:0] frame();
      return {a_sel, n_d_oe, n_text_cs, n_text_we, n_color_cs, n_color_we};
   endfunction

   task automatic check_frame(input string name, input logic color);
      check(name, frame(), color ? 6'b101100 : 6'b100011);
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; wr_req = 1'b0; ram_busy = 1'b0; busy_soon = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic sample_write(input int c);
      if (!n_text_we || !n_color_we) begin
         obs_q.push_back({!n_color_we, ram_a, ram_d});
         obs_t.push_back(c);
         check_frame("write_frame", !n_color_we);
      end
   endtask

   task automatic collect(input int n);
      obs_q.delete(); obs_t.delete(); asel_t = -1;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         if (asel_t < 0 && a_sel) asel_t = c;
         sample_write(c);
      end
   endtask

   task automatic write_once(input logic [15:0] a, input logic [7:0] d);
      @(negedge clk);
      wr_req = 1'b1; wr_addr = a; wr_data = d;
      #1 check("write_n_rdy", n_rdy, 1'b0);
   endtask

   // One randomized cycle: observe, drive, check n_rdy, advance model.
   task automatic rnd_step(input bit allow_cpu);
      logic [20:0] got;
      logic        inr, acc;
      @(negedge clk);
      if (!n_text_we || !n_color_we) begin
         got = {!n_color_we, ram_a, ram_d};
         check_frame("rnd_frame", !n_color_we);
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rnd_extra_write: got 0x%0h, expected no write", got);
         end else begin
            check("rnd_write", got, exp_q.pop_front());
         end
         pop_dly = 2;   // head leaves the FIFO at the end of HOLD
      end
      if (!allow_cpu) begin
         ram_busy = 1'b0; busy_soon = 1'b0;
      end else begin
         if (scan_left > 0) scan_left--;
         if (scan_left == 0) begin
            case (scan_ph)
               0: begin scan_ph = 1; busy_soon = 1'b1; ram_busy = 1'b0; scan_left = 3; end
               1: begin scan_ph = 2; busy_soon = 1'b0; ram_busy = 1'b1; scan_left = $urandom_range(5, 30); end
               default: begin scan_ph = 0; busy_soon = 1'b0; ram_busy = 1'b0; scan_left = $urandom_range(1, 20); end
            endcase
         end
      end
      if (!pending) begin
         if (allow_cpu && $urandom_range(0, 3) != 0) begin
            wr_req = 1'b1;
            if ($urandom_range(0, 7) == 0) begin
               wr_addr = {3'($urandom_range(0, 6)), 13'($urandom)};
            end else begin
               // distinct from the previous in-range address: no same-address merge
               last_low = last_low + 13'($urandom_range(1, 50));
               wr_addr  = {3'b111, last_low};
            end
            wr_data = 8'($urandom);
         end else begin
            wr_req = 1'b0;
         end
      end
      #1;
      inr = wr_req && (wr_addr[15:13] == 3'b111);
      check("rnd_n_rdy", n_rdy, inr && (mcount == DEPTH));
      acc = inr && (mcount < DEPTH);
      if (acc) exp_q.push_back({wr_addr[12:0], wr_data});
      pending = inr && !acc;
      @(posedge clk);
      if (acc) mcount++;
      if (pop_dly == 1) mcount--;
      if (pop_dly > 0) pop_dly--;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [15:0] addr;
      logic [7:0]  data;
      int          sel;    // 0 none, 1 text, 2 color
      logic [11:0] a;
   } vec_t;

   localparam int NV = 8;
   vec_t vecs[NV];

   initial begin
      logic ok;
      vecs[0] = '{16'hE005, 8'h41, 1, 12'h005};
      vecs[1] = '{16'hF123, 8'h5A, 2, 12'h123};
      vecs[2] = '{16'hFFFF, 8'hFF, 2, 12'hFFF};
      vecs[3] = '{16'hE000, 8'h00, 1, 12'h000};
      vecs[4] = '{16'hEFFF, 8'hC3, 1, 12'hFFF};
      vecs[5] = '{16'h8000, 8'hAA, 0, 12'h000};
      vecs[6] = '{16'hDFFF, 8'h11, 0, 12'h000};
      vecs[7] = '{16'h7000, 8'h22, 0, 12'h000};

      // reset values while rst is held
      @(negedge clk);
      check("reset_flags", {n_rdy, frame(), abort_err}, 8'b00111110);
      check("reset_ram_ad", {ram_a, ram_d}, 20'h0);
      do_reset();

      // table: one write, then one full drain sequence (or none)
      for (int v = 0; v < NV; v++) begin
         write_once(vecs[v].addr, vecs[v].data);
         @(negedge clk);
         wr_req = 1'b0;
         check("vec_idle_before_setup", a_sel, 1'b0);
         collect(8);
         if (vecs[v].sel == 0) begin
            check("vec_no_write", obs_q.size(), 0);
            check("vec_no_asel", asel_t, -1);
         end else begin
            check("vec_write_count", obs_q.size(), 1);
            check("vec_setup_cycle", asel_t, 0);
            if (obs_q.size() > 0) begin
               check("vec_write", obs_q[0], {vecs[v].sel == 2, vecs[v].a, vecs[v].data});
               check("vec_strobe_cycle", obs_t[0], 1);
            end
         end
         check("vec_end_idle", frame(), 6'b011111);
      end

      // full FIFO stall while scan-out owns the RAMs
      do_reset();
      ram_busy = 1'b1;
      for (int i = 0; i < 4; i++) write_once(16'hF000 + 16'(i), 8'h10 + 8'(i));
      @(negedge clk);
      wr_addr = 16'hF004; wr_data = 8'h14;
      #1 check("full_stall", n_rdy, 1'b1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("full_stall_hold", n_rdy, 1'b1);
         check("full_no_asel", a_sel, 1'b0);
      end
      ram_busy = 1'b0;
      obs_q.delete(); obs_t.delete();
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         sample_write(c);
         if (c < 3) check("full_stall_until_pop", n_rdy, 1'b1);
         if (c == 3) check("full_release", n_rdy, 1'b0);
         if (c == 4) wr_req = 1'b0;
      end
      check("full_write_count", obs_q.size(), 5);
      for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
         check("full_write", obs_q[i], {1'b1, 12'(i), 8'h10 + 8'(i)});
         if (i > 0) check("full_spacing", obs_t[i] - obs_t[i-1], 4);
      end

      // abort during STROBE, then retry of the same head entry
      do_reset();
      write_once(16'hE033, 8'h77);
      @(negedge clk);
      wr_req = 1'b0;
      ok = 1'b0;
      for (int c = 0; c < 10 && !ok; c++) begin
         @(negedge clk);
         if (!n_text_we) ok = 1'b1;
      end
      check("abort_reached_strobe", ok, 1'b1);
      check("abort_err_clear_before", abort_err, 1'b0);
      ram_busy = 1'b1;
      @(negedge clk);
      check("abort_frame", frame(), 6'b011111);
      check("abort_err_set", abort_err, 1'b1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("abort_hold_off", frame(), 6'b011111);
      end
      ram_busy = 1'b0;
      collect(10);
      check("abort_retry_count", obs_q.size(), 1);
      if (obs_q.size() > 0) check("abort_retry_write", obs_q[0], {1'b0, 12'h033, 8'h77});
      check("abort_err_sticky", abort_err, 1'b1);

      // busy_soon blocks a new drain
      do_reset();
      busy_soon = 1'b1;
      write_once(16'hE100, 8'h3C);
      @(negedge clk);
      wr_req = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         check("busy_soon_blocks", {a_sel, n_text_cs}, 2'b01);
      end
      busy_soon = 1'b0;
      collect(10);
      check("busy_soon_count", obs_q.size(), 1);
      if (obs_q.size() > 0) check("busy_soon_write", obs_q[0], {1'b0, 12'h100, 8'h3C});

      // asynchronous reset in the middle of a drain drops the queue
      do_reset();
      write_once(16'hE044, 8'h99);
      @(negedge clk);
      wr_req = 1'b0;
      ok = 1'b0;
      for (int c = 0; c < 10 && !ok; c++) begin
         @(negedge clk);
         if (a_sel) ok = 1'b1;
      end
      check("rst_mid_reached_setup", ok, 1'b1);
      #2 rst = 1'b1;
      #1 check("rst_mid_frame", frame(), 6'b011111);
      @(negedge clk);
      rst = 1'b0;
      collect(8);
      check("rst_mid_dropped", obs_q.size(), 0);

      // two writes to the same address while the RAMs are busy
      do_reset();
      ram_busy = 1'b1;
      write_once(16'hE010, 8'h01);
      write_once(16'hE010, 8'h02);
      @(negedge clk);
      wr_req = 1'b0; ram_busy = 1'b0;
      collect(16);
`ifdef VGA_WBUF_COALESCE_EN
      check("same_addr_count", obs_q.size(), 1);
      if (obs_q.size() > 0) check("same_addr_write", obs_q[0], {1'b0, 12'h010, 8'h02});
`else
      check("same_addr_count", obs_q.size(), 2);
      if (obs_q.size() > 1) begin
         check("same_addr_write0", obs_q[0], {1'b0, 12'h010, 8'h01});
         check("same_addr_write1", obs_q[1], {1'b0, 12'h010, 8'h02});
      end
`endif

      // randomized traffic against the queue model
      do_reset();
      exp_q.delete();
      mcount = 0; pop_dly = 0; pending = 1'b0;
      scan_ph = 0; scan_left = 5; last_low = 13'($urandom);
      for (int i = 0; i < 3000; i++) rnd_step(1'b1);
      for (int i = 0; i < 300 && (exp_q.size() != 0 || pop_dly != 0 || pending); i++) rnd_step(1'b0);
      check("rnd_all_drained", exp_q.size(), 0);
      check("rnd_no_abort", abort_err, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
